// File: rtl/matvec_sched_if.sv
// rtl/matvec_sched_if.sv - requester, engine and result signals of the matvec scheduler
// master is the scheduler side, slave is the requester/engine/consumer side.
interface matvec_sched_if #(
  parameter int N_REQ   = 4,
  parameter int IN_C    = 34,
  parameter int OUT_C   = 32,
  parameter int P_WIDTH = 8,
  parameter int B_WIDTH = 24
);
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0]               req_ready;
  logic [N_REQ*IN_C*P_WIDTH-1:0]  req_feature_pack;
  logic                           mv_clean;
  logic                           mv_calc_en;
  logic [IN_C*P_WIDTH-1:0]        mv_feature_pack;
  logic [OUT_C*B_WIDTH-1:0]       mv_accum_pack;
  logic                           mv_accum_valid;
  logic                           out_valid;
  logic                           out_ready;
  logic [OUT_C*B_WIDTH-1:0]       out_accum_pack;
  logic [$clog2(N_REQ)-1:0]       out_src;

  modport master (
    input  req_valid, req_feature_pack, mv_accum_pack, mv_accum_valid, out_ready,
    output req_ready, mv_clean, mv_calc_en, mv_feature_pack, out_valid, out_accum_pack, out_src
  );

  modport slave (
    output req_valid, req_feature_pack, mv_accum_pack, mv_accum_valid, out_ready,
    input  req_ready, mv_clean, mv_calc_en, mv_feature_pack, out_valid, out_accum_pack, out_src
  );
endinterface

// File: rtl/matvec_sched.sv
// rtl/matvec_sched.sv - round-robin scheduler sharing one matvec engine between requesters
// One job in flight: accept, clear engine, run until accum valid or watchdog expiry, hand result out.
module matvec_sched #(
  parameter int N_REQ       = 4,
  parameter int IN_C        = 34,
  parameter int OUT_C       = 32,
  parameter int MAC_LATENCY = 4,
  parameter int TIMEOUT     = 64,
  parameter int P_WIDTH     = 8,
  parameter int B_WIDTH     = 24
) (
  input  logic              clk,
  input  logic              rst,
  matvec_sched_if.master    bus,
  output logic              busy,
  output logic              err_timeout
);
  localparam int SW          = $clog2(N_REQ);
  localparam int FW          = IN_C * P_WIDTH;
  localparam int AW          = OUT_C * B_WIDTH;
  // A watchdog shorter than the engine's own latency would abort every job.
  localparam int MIN_TIMEOUT = IN_C + MAC_LATENCY + 2;
  localparam int TO_LIMIT    = (TIMEOUT < MIN_TIMEOUT) ? MIN_TIMEOUT : TIMEOUT;
  localparam int CW          = $clog2(TO_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]       state;
  logic [SW-1:0]    last_grant;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    src_q;
  logic [N_REQ-1:0] grant_oh;
  logic             grant_found;
  logic [FW-1:0]    feat_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    wd_cnt;
  logic             abort_clean;
  logic             err_q;
  logic             wd_expire;
  logic [SW:0]      cand;

  // Search starts one past the last winner so a re-requesting winner goes to the back.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + (SW+1)'(k);
      if (cand >= (SW+1)'(N_REQ)) begin
        cand = cand - (SW+1)'(N_REQ);
      end
      if (!grant_found && bus.req_valid[cand[SW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SW-1:0];
      end
    end
    if (grant_found) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign wd_expire = (wd_cnt == CW'(TO_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= SW'(N_REQ - 1);
      src_q       <= '0;
      feat_q      <= '0;
      acc_q       <= '0;
      wd_cnt      <= '0;
      abort_clean <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      abort_clean <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            feat_q     <= bus.req_feature_pack[int'(grant_idx)*FW +: FW];
            src_q      <= grant_idx;
            last_grant <= grant_idx;
            state      <= S_START;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_CALC;
        end
        S_CALC: begin
          if (bus.mv_accum_valid) begin
            acc_q <= bus.mv_accum_pack;
            state <= S_OUT;
          end else if (wd_expire) begin
            err_q       <= 1'b1;
            abort_clean <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while rst is high, except mv_clean which holds the engine cleared.
  assign bus.req_ready       = (!rst && state == S_IDLE) ? grant_oh : '0;
  assign bus.mv_clean        = rst || (state == S_START) || abort_clean;
  assign bus.mv_calc_en      = !rst && (state == S_CALC);
  assign bus.mv_feature_pack = rst ? '0 : feat_q;
  assign bus.out_valid       = !rst && (state == S_OUT);
  assign bus.out_accum_pack  = rst ? '0 : acc_q;
  assign bus.out_src         = rst ? '0 : src_q;
  assign busy                = !rst && (state != S_IDLE);
  assign err_timeout         = !rst && err_q;
endmodule

// File: tb/tb_matvec_sched.sv
// tb/tb_matvec_sched.sv - directed bench for matvec_sched with a behavioural matvec engine
// Engine raises accum valid IN_C+MAC_LATENCY cycles into a run; results are W*x with a fixed W.
module tb_matvec_sched;
  localparam int N_REQ   = 4;
  localparam int IN_C    = 34;
  localparam int OUT_C   = 32;
  localparam int MAC_LAT = 4;
  localparam int TIMEOUT = 64;
  localparam int PW      = 8;
  localparam int BW      = 24;
  localparam int FW      = IN_C * PW;
  localparam int AW      = OUT_C * BW;

  logic clk;
  logic rst;
  logic busy;
  logic err_timeout;
  logic force_valid;
  logic eng_mute;
  logic [FW-1:0] feat [N_REQ];
  int ecnt;
  int n_vec;
  int n_miss;

  matvec_sched_if #(.N_REQ(N_REQ), .IN_C(IN_C), .OUT_C(OUT_C), .P_WIDTH(PW), .B_WIDTH(BW)) bus ();

  matvec_sched #(
    .N_REQ(N_REQ), .IN_C(IN_C), .OUT_C(OUT_C), .MAC_LATENCY(MAC_LAT),
    .TIMEOUT(TIMEOUT), .P_WIDTH(PW), .B_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] golden(input logic [FW-1:0] f);
    logic [BW-1:0] s;
    golden = '0;
    for (int o = 0; o < OUT_C; o++) begin
      s = '0;
      for (int i = 0; i < IN_C; i++) begin
        s = s + BW'((o*3 + i*7) % 13 + 1) * BW'(f[i*PW +: PW]);
      end
      golden[o*BW +: BW] = s;
    end
  endfunction

  function automatic logic [FW-1:0] make_feat(input int base);
    make_feat = '0;
    for (int k = 0; k < IN_C; k++) begin
      make_feat[k*PW +: PW] = PW'(base + k);
    end
  endfunction

  always_comb begin
    bus.req_feature_pack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_feature_pack[i*FW +: FW] = feat[i];
    end
  end

  always @(posedge clk) begin
    if (bus.mv_clean || !bus.mv_calc_en) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end
  assign bus.mv_accum_valid = force_valid || (bus.mv_calc_en && !eng_mute && ecnt == IN_C + MAC_LAT);
  assign bus.mv_accum_pack  = golden(bus.mv_feature_pack);

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(output int idx);
    int n;
    n = 0;
    idx = -1;
    while (bus.req_ready == '0 && n < 100) begin
      step();
      n++;
    end
    check("grant_onehot", 1024'($onehot(bus.req_ready)), 1);
    for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) idx = i;
  endtask

  task automatic run_from_accept(input int idx, input bit keep, input int hold);
    int n;
    logic [AW-1:0] exp_acc;
    exp_acc = golden(feat[idx]);
    step();
    n = 1;
    if (!keep) bus.req_valid[idx] = 1'b0;
    check("start_clean", bus.mv_clean, 1);
    check("start_calc_en", bus.mv_calc_en, 0);
    check("start_busy", busy, 1);
    check("feature_latched", bus.mv_feature_pack, feat[idx]);
    step();
    n = 2;
    check("calc_en", bus.mv_calc_en, 1);
    check("calc_clean", bus.mv_clean, 0);
    check("calc_req_ready", bus.req_ready, 0);
    while (!bus.out_valid && n < 200) begin
      step();
      n++;
    end
    check("out_latency", n, 41);
    check("out_src", bus.out_src, idx);
    check("out_accum", bus.out_accum_pack, exp_acc);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", bus.out_valid, 1);
      check("hold_accum", bus.out_accum_pack, exp_acc);
      check("hold_src", bus.out_src, idx);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("post_out_valid", bus.out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int n;
    logic saw;
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    force_valid = 1'b0;
    eng_mute = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) feat[i] = '0;
    step();
    step();

    // reset state, with a request pending
    bus.req_valid = 4'b0001;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_clean", bus.mv_clean, 1);
    check("rst_calc_en", bus.mv_calc_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);
    check("idle_clean", bus.mv_clean, 0);

    // stray accum valid in IDLE
    force_valid = 1'b1;
    step();
    force_valid = 1'b0;
    check("stray_valid_out", bus.out_valid, 0);
    check("stray_valid_busy", busy, 0);

    // single job
    feat[0] = make_feat(1);
    bus.req_valid = 4'b0001;
    #1;
    wait_accept(idx);
    check("t1_grant", idx, 0);
    if (idx >= 0) run_from_accept(idx, 1'b0, 0);

    // reset mid-CALC
    feat[3] = make_feat(50);
    bus.req_valid = 4'b1000;
    #1;
    wait_accept(idx);
    check("rst_job_grant", idx, 3);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("mid_rst_clean", bus.mv_clean, 1);
      check("mid_rst_calc_en", bus.mv_calc_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_ready", bus.req_ready, 0);
      check("mid_rst_feature", bus.mv_feature_pack, 0);
      check("mid_rst_out_valid", bus.out_valid, 0);
      if (i == 0) step();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      saw = saw | bus.out_valid | busy;
    end
    check("post_rst_quiet", saw, 0);

    // round robin with every requester held valid
    for (int i = 0; i < N_REQ; i++) feat[i] = make_feat(10 + i*5);
    bus.req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      wait_accept(idx);
      check("rr_grant", idx, j % 4);
      if (idx >= 0) run_from_accept(idx, 1'b1, 0);
    end
    bus.req_valid = '0;
    step();

    // backpressure on req1 with req2 pending, then back-to-back accept of req2
    feat[1] = make_feat(70);
    feat[2] = make_feat(90);
    bus.req_valid = 4'b0110;
    #1;
    wait_accept(idx);
    check("bp_grant", idx, 1);
    if (idx >= 0) run_from_accept(idx, 1'b0, 20);
    check("b2b_next_grant", bus.req_ready, 4'b0100);
    wait_accept(idx);
    check("b2b_grant", idx, 2);
    if (idx >= 0) run_from_accept(idx, 1'b0, 0);

    // watchdog timeout
    feat[1] = make_feat(5);
    eng_mute = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    wait_accept(idx);
    check("to_grant", idx, 1);
    step();
    n = 1;
    bus.req_valid = '0;
    saw = 1'b0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
      saw = saw | bus.out_valid;
    end
    check("to_cycle", n, 66);
    check("to_clean", bus.mv_clean, 1);
    check("to_busy", busy, 0);
    step();
    check("to_clean_end", bus.mv_clean, 0);
    check("to_sticky", err_timeout, 1);
    check("to_no_out", saw | bus.out_valid, 0);
    eng_mute = 1'b0;
    feat[2] = make_feat(33);
    bus.req_valid = 4'b0100;
    #1;
    wait_accept(idx);
    check("after_to_grant", idx, 2);
    if (idx >= 0) run_from_accept(idx, 1'b0, 0);
    check("err_sticky_end", err_timeout, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
